// File: rtl/pipe_stage_chain.sv
// ---------------------------------------------------------------------------
// pipe_stage_chain
//
// A parametrised run of pipeline registers with a ready/valid handshake. Each
// stage has its own stall and flush controls. The chain also exposes the valid
// bit and payload of every stage so that hazard and forwarding logic can
// inspect the stages.
//
// Parameters:
//   DATA_W  payload width per stage
//   STAGES  number of register stages (>=1); stage 0 is nearest the input
//   CNT_W   width of each saturating performance counter
//
// Ports:
//   clock         sole clock, rising edge
//   reset         asynchronous, active-low reset
//   in_valid      upstream item present
//   in_ready      chain accepts in_data this cycle
//   in_data       upstream payload
//   out_valid     item leaving the last stage
//   out_ready     downstream accepts
//   out_data      payload of the last stage
//   stall         bit k freezes stage k
//   flush         bit k kills the content of stage k
//   clr_stats     synchronous clear of both counters
//   stage_valid   registered valid bit per stage
//   stage_data    flattened stage payloads, stage k at [k*DATA_W +: DATA_W]
//   occupancy     popcount of stage_valid
//   stall_cycles  cycles with in_valid & ~in_ready (saturating)
//   kill_count    valid items discarded by flush (saturating)
// ---------------------------------------------------------------------------
module pipe_stage_chain #(
  parameter  int DATA_W = 64,
  parameter  int STAGES = 3,
  parameter  int CNT_W  = 16,
  localparam int OCC_W  = $clog2(STAGES + 1)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  input  logic [STAGES-1:0]        stall,
  input  logic [STAGES-1:0]        flush,
  input  logic                     clr_stats,
  output logic [STAGES-1:0]        stage_valid,
  output logic [STAGES*DATA_W-1:0] stage_data,
  output logic [OCC_W-1:0]         occupancy,
  output logic [CNT_W-1:0]         stall_cycles,
  output logic [CNT_W-1:0]         kill_count
);

  localparam int SUM_W = CNT_W + OCC_W;

  logic [STAGES-1:0]             valid_q, valid_d;
  logic [STAGES-1:0][DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]              stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]              kill_cnt_q, kill_cnt_d;

  logic [STAGES-1:0]             ready;
  logic [STAGES-1:0]             ov;
  logic [STAGES-1:0]             iv;
  logic [STAGES-1:0][DATA_W-1:0] inc_data;
  logic [OCC_W-1:0]              occ_c;
  logic [OCC_W-1:0]              kills_c;
  logic [SUM_W-1:0]              kill_sum;

  // Ready ripples from the output back to the input. A local carries
  // ready_{k+1} so that no signal feeds itself.
  always_comb begin : ready_chain
    logic nxt;
    nxt   = out_ready;
    ready = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      ready[k] = flush[k] | (~stall[k] & (~valid_q[k] | nxt));
      nxt      = ready[k];
    end
  end

  assign ov = valid_q & ~stall & ~flush;

  // Each stage is fed by its predecessor's outgoing valid/data; stage 0 is
  // fed by the upstream port.
  always_comb begin
    iv          = '0;
    inc_data    = '0;
    iv[0]       = in_valid;
    inc_data[0] = in_data;
    for (int k = 1; k < STAGES; k++) begin
      iv[k]       = ov[k-1];
      inc_data[k] = data_q[k-1];
    end
  end

  // A flush drops the stage valid bit and swallows anything offered into the
  // stage that cycle. A ready stage otherwise takes its input or a bubble.
  // Payload only moves with a valid item.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    for (int k = 0; k < STAGES; k++) begin
      if (flush[k]) begin
        valid_d[k] = 1'b0;
      end else if (ready[k]) begin
        valid_d[k] = iv[k];
        if (iv[k]) begin
          data_d[k] = inc_data[k];
        end
      end
    end
  end

  // Popcounts for the occupancy output and for the number of valid items
  // that are killed this cycle.
  always_comb begin
    occ_c   = '0;
    kills_c = '0;
    for (int k = 0; k < STAGES; k++) begin
      occ_c   = occ_c + OCC_W'(valid_q[k]);
      kills_c = kills_c + OCC_W'(flush[k] & valid_q[k]);
    end
  end

  // Both counters saturate. The kill counter can jump by several in one
  // cycle, so its sum is formed one field wider before it is clamped.
  always_comb begin
    kill_sum    = {{OCC_W{1'b0}}, kill_cnt_q} + {{CNT_W{1'b0}}, kills_c};
    stall_cnt_d = stall_cnt_q;
    kill_cnt_d  = kill_cnt_q;
    if (clr_stats) begin
      stall_cnt_d = '0;
      kill_cnt_d  = '0;
    end else begin
      if (in_valid && !ready[0] && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_d = stall_cnt_q + 1'b1;
      end
      if (kill_sum > {{OCC_W{1'b0}}, {CNT_W{1'b1}}}) begin
        kill_cnt_d = {CNT_W{1'b1}};
      end else begin
        kill_cnt_d = kill_sum[CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q     <= '0;
      data_q      <= '0;
      stall_cnt_q <= '0;
      kill_cnt_q  <= '0;
    end else begin
      valid_q     <= valid_d;
      data_q      <= data_d;
      stall_cnt_q <= stall_cnt_d;
      kill_cnt_q  <= kill_cnt_d;
    end
  end

  assign in_ready     = ready[0];
  assign out_valid    = ov[STAGES-1];
  assign out_data     = data_q[STAGES-1];
  assign stage_valid  = valid_q;
  assign stage_data   = data_q;
  assign occupancy    = occ_c;
  assign stall_cycles = stall_cnt_q;
  assign kill_count   = kill_cnt_q;

endmodule

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
- Parametrised chain of pipeline registers with a ready/valid handshake.
- Each stage has its own stall and flush control, plus per-stage valid tracking and saturating performance counters.
- Replaces hand-written fixed-width stage registers. The core uses it for any run of stages that needs hazard stalls, branch flushes and bubble insertion.
- Exposes per-stage valid and data for hazard/forwarding logic.

Parameters:
- DATA_W, 64, payload width per stage.
- STAGES, 3, number of register stages (≥1). Stage 0 is nearest the input.
- CNT_W, 16, width of each performance counter.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream item present.
- in_ready  out  1  chain accepts in_data this cycle.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  item leaving last stage.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  payload of last stage.
- stall  in  STAGES  bit k freezes stage k.
- flush  in  STAGES  bit k kills the content of stage k.
- clr_stats  in  1  synchronous clear of counters.
- stage_valid  out  STAGES  registered valid bit per stage.
- stage_data  out  STAGES*DATA_W  flattened stage payloads; stage k at bits [k*DATA_W +: DATA_W].
- occupancy  out  $clog2(STAGES+1)  popcount of stage_valid.
- stall_cycles  out  CNT_W  cycles with in_valid & ~in_ready.
- kill_count  out  CNT_W  valid items discarded by flush.

Behaviour:
- Reset (reset=0, no clock edge needed): all stage_valid=0, all stage_data=0, counters=0, out_valid=0.
- Combinational ready chain, with ready_STAGES = out_ready:
  - ready_k = flush[k] | (~stall[k] & (~stage_valid[k] | ready_{k+1})).
- Outgoing valid of stage k: ov_k = stage_valid[k] & ~stall[k] & ~flush[k].
- Port mapping: in_ready = ready_0; out_valid = ov_{STAGES-1}; out_data = stage_data of the last stage.
- Incoming valid: iv_0 = in_valid; iv_k = ov_{k-1}.
- Per stage at each rising edge, in priority order:
  - flush[k]: stage_valid[k]<=0, data unchanged. Any item offered into stage k that cycle is discarded; upstream sees it as transferred.
  - else ready_k: stage_valid[k]<=iv_k; stage_data[k]<=incoming data only when iv_k=1, otherwise data is held.
  - else hold: valid and data unchanged.
- Stall of stage k:
  - Stage k holds its content.
  - Stage k+1 loads a bubble if it is ready.
  - Stalls propagate backpressure to stages 0..k-1 through the ready chain only.
- Flush has priority over stall on the same stage.
- Latency: with no stall/flush and out_ready=1, an item accepted at edge N is presented on out_valid after edge N+STAGES-1. It transfers at edge N+STAGES. Throughput is 1 item/cycle.
- Full chain with out_ready=0 and no flush: in_ready=0. The chain is never overwritten and never reorders.
- Simultaneous out_ready and in_valid when full: shift-through, so in_ready=1 (no bubble).
- Payload of an invalid stage is don't-care for checking, except after reset (0).
- occupancy: combinational popcount of stage_valid.
- stall_cycles: +1 per cycle with in_valid & ~in_ready; saturates at all-ones.
- kill_count: + number of stages with flush[k] & stage_valid[k] per cycle; saturates at all-ones.
- clr_stats: both counters go to 0 at the next edge. It takes priority over increment.
- Reset asserted mid-operation: the in-flight contents are lost. No partial outputs; out_valid falls asynchronously.

Test Plan:
- Reset: drive reset=0 with a full chain mid-cycle → stage_valid=0, out_valid=0, counters=0 immediately. After release, in_ready=1.
- Stream (STAGES=3): push 0x10..0x17 on consecutive edges with out_ready=1 → out_valid rises 2 edges after the first accept. Outputs are 0x10..0x17 on consecutive cycles; occupancy holds at 3 at steady state; stall_cycles=0.
- Backpressure: out_ready=0, push 0xA,0xB,0xC,0xD → in_ready=0 after 3 accepts, with 0xD held and stall_cycles increments each cycle. Raise out_ready → outputs 0xA,0xB,0xC,0xD in order with no gap.
- Mid stall: streaming, stall[1]=1 for 2 cycles → stage2 receives 2 bubbles and out_valid shows a 2-cycle gap. Stage0 holds, in_ready=0 for 2 cycles, no data lost.
- Flush: chain holds A(s2), B(s1), C(s0), out_ready=0; assert flush=3'b011 for one cycle while in_valid=1 with D → only A survives. D is discarded, kill_count=2, occupancy=1.
- Counter saturation/clear: CNT_W=4, hold in_valid=1 against a full chain for 20 cycles → stall_cycles=15. Pulse clr_stats → 0 at the next edge.
